simple_dma_controller: RTL and testbench

- Responder end of the single-device DMA handshake: serves word-block transfer requests raised by a DMA device.
- Sequences one memory access per word through the core's DMA master port (dma_addr/dma_en/dma_we/dma_din/dma_dout/dma_ready).
- Returns read data and a per-word acknowledge to the device; signals end of block.
- Sits between the device's request outputs and the openMSP430-style DMA interface.

---
 rtl/dma_ctrl_pkg.sv | 30 +++
 rtl/simple_dma_controller_if.sv | 22 ++
 rtl/dma_ctrl_timer.sv | 30 +++
 rtl/simple_dma_controller.sv | 170 +++++++++++++++++
 tb/tb_simple_dma_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the simple DMA controller: FSM encoding, transfer direction, write enables.
package dma_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_DEV = 3'd1;
  localparam logic [2:0] ST_MEM_REQ  = 3'd2;
  localparam logic [2:0] ST_MEM_RD   = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_DEV = ST_WAIT_DEV,
    MEM_REQ  = ST_MEM_REQ,
    MEM_RD   = ST_MEM_RD,
    ACK      = ST_ACK,
    DONE     = ST_DONE
  } state_t;

  localparam logic DMA_RD = 1'b1;
  localparam logic DMA_WR = 1'b0;

  localparam logic [1:0] WE_WORD = 2'b11;

  // Memory port is word addressed; byte address bit 0 is dropped.
  function automatic logic [14:0] word_addr(input logic [15:0] byte_addr);
    return byte_addr[15:1];
  endfunction

endpackage

// File: rtl/simple_dma_controller_if.sv
// openMSP430-style DMA master port: controller drives the request side, memory answers with ready/read data.
interface simple_dma_controller_if;

  logic [14:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_priority;

  modport master (
    output dma_addr, dma_en, dma_we, dma_din, dma_priority,
    input  dma_dout, dma_ready
  );

  modport slave (
    input  dma_addr, dma_en, dma_we, dma_din, dma_priority,
    output dma_dout, dma_ready
  );

endinterface

// File: rtl/dma_ctrl_timer.sv
// Device-acknowledge watchdog: counts ticks since the last clear, expires on the LIMIT-th tick.
// LIMIT of 0 disables expiry entirely.
module dma_ctrl_timer #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 16'd1;
    end
  end

  // Consulted only on a tick cycle, so the current tick is the LIMIT-th one.
  assign expire = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/simple_dma_controller.sv
// DMA responder: one memory access per word, one-cycle dma_ack per word; 3 cycles/word write, 4 read; dma_en held until dma_ready.
// Build option DMA_CTRL_PRIORITY_EN drives dma_priority during long blocks; otherwise it is tied low.
module simple_dma_controller
  import dma_ctrl_pkg::*;
#(
  parameter logic [15:0] ADDR_STEP   = 16'd2,
  parameter int          ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_timeout,
  simple_dma_controller_if.master mem
);

  state_t      state, state_nxt;
  logic [15:0] addr, cnt, data_q, dev_in_q;
  logic        dir, timeout_q, drop;
  logic        accept, tmr_clear, tmr_tick, tmr_expire, timeout_hit;
  logic        ack_o, end_o, en_o;
  logic [14:0] addr_o;
  logic [1:0]  we_o;
  logic [15:0] din_o;

  dma_ctrl_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .tick   (tmr_tick),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    tmr_clear   = 1'b1;
    tmr_tick    = 1'b0;
    timeout_hit = 1'b0;
    ack_o       = 1'b0;
    end_o       = 1'b0;
    en_o        = 1'b0;
    addr_o      = '0;
    we_o        = '0;
    din_o       = '0;
    case (state)
      IDLE: begin
        if (dma_rqst) begin
          accept    = 1'b1;
          state_nxt = (dma_num_words == 16'd0) ? DONE : WAIT_DEV;
        end
      end
      WAIT_DEV: begin
        tmr_clear = 1'b0;
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end else if (dev_ack) begin
          state_nxt = MEM_REQ;
        end else begin
          tmr_tick = 1'b1;
          if (tmr_expire) begin
            timeout_hit = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      MEM_REQ: begin
        en_o   = 1'b1;
        addr_o = word_addr(addr);
        if (dir == DMA_WR) begin
          we_o  = WE_WORD;
          din_o = data_q;
        end
        if (mem.dma_ready) begin
          state_nxt = (dir == DMA_RD) ? MEM_RD : ACK;
        end
      end
      MEM_RD: begin
        state_nxt = ACK;
      end
      ACK: begin
        ack_o = 1'b1;
        // A request dropped mid-word still completes that word, then abandons the block.
        if (drop || !dma_rqst) begin
          state_nxt = IDLE;
        end else if (cnt == 16'd1) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT_DEV;
        end
      end
      DONE: begin
        end_o = 1'b1;
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      data_q    <= '0;
      dev_in_q  <= '0;
      timeout_q <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= dma_start_address & 16'hFFFE;
        cnt       <= dma_num_words;
        dir       <= dma_rd_wr;
        timeout_q <= 1'b0;
        drop      <= 1'b0;
      end
      if ((state == WAIT_DEV) && dma_rqst && dev_ack && (dir == DMA_WR)) begin
        data_q <= dev_out;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (state == MEM_RD) begin
        dev_in_q <= mem.dma_dout;
      end
      if (state == ACK) begin
        addr <= addr + ADDR_STEP;
        cnt  <= cnt - 16'd1;
      end
      if (((state == MEM_REQ) || (state == MEM_RD)) && !dma_rqst) begin
        drop <= 1'b1;
      end
    end
  end

  assign dev_in       = dev_in_q;
  assign dma_ack      = ack_o;
  assign dma_end_flag = end_o;
  assign dma_timeout  = timeout_q;
  assign mem.dma_addr = addr_o;
  assign mem.dma_en   = en_o;
  assign mem.dma_we   = we_o;
  assign mem.dma_din  = din_o;

`ifdef DMA_CTRL_PRIORITY_EN
  assign mem.dma_priority = (state == MEM_REQ) && (cnt >= 16'd4);
`else
  assign mem.dma_priority = 1'b0;
`endif

endmodule

// File: tb/tb_simple_dma_controller.sv
// Directed bench for simple_dma_controller: memory model plus scoreboard of expected accesses and read data.
module tb_simple_dma_controller;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_rqst, dma_rd_wr, dev_ack;
  logic [15:0] dma_start_address, dma_num_words, dev_out;
  logic [15:0] dev_in;
  logic        dma_ack, dma_end_flag, dma_timeout;

  simple_dma_controller_if mem_if ();

  simple_dma_controller #(.ADDR_STEP(16'd2), .ACK_TIMEOUT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .dma_rqst          (dma_rqst),
    .dma_rd_wr         (dma_rd_wr),
    .dma_start_address (dma_start_address),
    .dma_num_words     (dma_num_words),
    .dev_ack           (dev_ack),
    .dev_out           (dev_out),
    .dev_in            (dev_in),
    .dma_ack           (dma_ack),
    .dma_end_flag      (dma_end_flag),
    .dma_timeout       (dma_timeout),
    .mem               (mem_if)
  );

  always #5 clk = ~clk;

  acc_t        exp_acc[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem_model [logic [14:0]];
  acc_t        e_acc;
  logic [15:0] e_rd;
  int          checks = 0;
  int          errors = 0;
  int          ack_seen = 0;
  logic        chk_rd = 1'b0;
  logic        rd_pend = 1'b0;
  logic [14:0] rd_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({dev_in, dma_ack, dma_end_flag, dma_timeout, mem_if.dma_addr,
                mem_if.dma_en, mem_if.dma_we, mem_if.dma_din, mem_if.dma_priority});
  endfunction

  task automatic push_acc(input logic [14:0] a, input logic [1:0] w, input logic [15:0] d);
    acc_t e;
    e.addr = a;
    e.we   = w;
    e.din  = d;
    exp_acc.push_back(e);
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_ack !== 1'b1 && n < 40);
    checks++;
    assert (dma_ack === 1'b1) else begin
      errors++;
      $error("FAIL %s: dma_ack observed %b after %0d cycles, expected 1", tag, dma_ack, n);
    end
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_if.dma_en !== 1'b1 && n < 40);
    checks++;
    assert (mem_if.dma_en === 1'b1) else begin
      errors++;
      $error("FAIL %s: dma_en observed %b after %0d cycles, expected 1", tag, mem_if.dma_en, n);
    end
  endtask

  task automatic drop_rqst(input string tag);
    @(posedge clk);
    #1 dma_rqst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk(tag, 64'(dma_end_flag), 64'd0);
  endtask

  // Memory model and scoreboard: read data appears the cycle after the accepted access.
  always @(negedge clk) begin
    mem_if.dma_dout = rd_pend ? mem_model[rd_addr] : 16'hDEAD;
    rd_pend = 1'b0;
    if (!reset && mem_if.dma_en === 1'b1) begin
      chk("priority", 64'(mem_if.dma_priority), 64'd0);
      if (mem_if.dma_ready === 1'b1) begin
        checks++;
        assert (exp_acc.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_access: observed addr %0h expected no access", mem_if.dma_addr);
        end
        if (exp_acc.size() != 0) begin
          e_acc = exp_acc.pop_front();
          chk("acc_addr", 64'(mem_if.dma_addr), 64'(e_acc.addr));
          chk("acc_we", 64'(mem_if.dma_we), 64'(e_acc.we));
          chk("acc_din", 64'(mem_if.dma_din), 64'(e_acc.din));
        end
        if (mem_if.dma_we == 2'b11) mem_model[mem_if.dma_addr] = mem_if.dma_din;
        else begin
          rd_pend = 1'b1;
          rd_addr = mem_if.dma_addr;
        end
      end
    end
    if (!reset && dma_ack === 1'b1) begin
      ack_seen++;
      if (chk_rd && exp_rd.size() != 0) begin
        e_rd = exp_rd.pop_front();
        chk("rd_data", 64'(dev_in), 64'(e_rd));
      end
    end
  end

  initial begin
    int n;
    int stall;
    reset = 1'b1;
    dma_rqst = 1'b0; dma_rd_wr = 1'b0; dma_start_address = '0; dma_num_words = '0;
    dev_ack = 1'b0; dev_out = '0; mem_if.dma_ready = 1'b1;
    mem_model[15'h0180] = 16'h1234;
    mem_model[15'h0181] = 16'h5678;
    @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Write 3 words from 0x0200; inputs disturbed after acceptance must not matter.
    dev_ack = 1'b1; dev_out = 16'hA001; dma_rd_wr = 1'b0;
    dma_start_address = 16'h0200; dma_num_words = 16'd3;
    push_acc(15'h0100, 2'b11, 16'hA001);
    push_acc(15'h0101, 2'b11, 16'hA002);
    push_acc(15'h0102, 2'b11, 16'hA003);
    dma_rqst = 1'b1;
    wait_ack("wr_ack0", n);
    chk("wr_first_lat", 64'(n), 64'd4);
    @(posedge clk);
    #1 dev_out = 16'hA002; dma_start_address = 16'h5555; dma_num_words = 16'd9; dma_rd_wr = 1'b1;
    wait_ack("wr_ack1", n);
    chk("wr_gap1", 64'(n), 64'd3);
    @(posedge clk);
    #1 dev_out = 16'hA003;
    wait_ack("wr_ack2", n);
    chk("wr_gap2", 64'(n), 64'd3);
    @(negedge clk);
    chk("wr_end", 64'(dma_end_flag), 64'd1);
    @(negedge clk);
    chk("wr_end_hold", 64'({dma_end_flag, mem_if.dma_en}), 64'b10);
    drop_rqst("wr_end_clr");

    // Read 2 words from 0x0300.
    @(posedge clk);
    #1 dma_rd_wr = 1'b1; dma_start_address = 16'h0300; dma_num_words = 16'd2; chk_rd = 1'b1;
    push_acc(15'h0180, 2'b00, 16'h0000);
    push_acc(15'h0181, 2'b00, 16'h0000);
    exp_rd.push_back(16'h1234);
    exp_rd.push_back(16'h5678);
    dma_rqst = 1'b1;
    wait_ack("rd_ack0", n);
    chk("rd_first_lat", 64'(n), 64'd5);
    wait_ack("rd_ack1", n);
    chk("rd_gap", 64'(n), 64'd4);
    @(negedge clk);
    chk("rd_end", 64'(dma_end_flag), 64'd1);
    chk("rd_hold", 64'(dev_in), 64'h5678);
    drop_rqst("rd_end_clr");
    chk_rd = 1'b0;

    // Zero-length block: straight to end flag, no memory access.
    @(posedge clk);
    #1 dma_rd_wr = 1'b0; dma_num_words = 16'd0; dma_start_address = 16'h0800; dma_rqst = 1'b1;
    @(negedge clk);
    chk("zero_idle", 64'(dma_end_flag), 64'd0);
    @(negedge clk);
    chk("zero_end", 64'({dma_end_flag, mem_if.dma_en}), 64'b10);
    drop_rqst("zero_end_clr");

    // Memory stall with request dropped mid-access.
    @(posedge clk);
    #1 mem_if.dma_ready = 1'b0; dev_out = 16'hBEEF; dma_start_address = 16'h0400; dma_num_words = 16'd2;
    push_acc(15'h0200, 2'b11, 16'hBEEF);
    dma_rqst = 1'b1;
    wait_en("stall_en");
    @(posedge clk);
    #1 dma_rqst = 1'b0;
    stall = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_if.dma_en === 1'b1) stall++;
    end
    chk("stall_en_held", 64'(stall), 64'd5);
    @(posedge clk);
    #1 mem_if.dma_ready = 1'b1;
    wait_ack("stall_ack", n);
    chk("stall_ack_lat", 64'(n), 64'd2);
    @(negedge clk);
    chk("stall_idle", 64'({dma_end_flag, mem_if.dma_en, dma_ack}), 64'd0);
    @(negedge clk);
    chk("stall_no_more", 64'({dma_end_flag, mem_if.dma_en}), 64'd0);

    // Device never acknowledges: abort after 8 waiting cycles.
    @(posedge clk);
    #1 dev_ack = 1'b0; dma_start_address = 16'h0600; dma_num_words = 16'd1; dma_rqst = 1'b1;
    repeat (9) @(negedge clk);
    chk("tmo_not_yet", 64'({dma_timeout, mem_if.dma_en}), 64'd0);
    @(posedge clk);
    #1 dma_rqst = 1'b0;
    @(negedge clk);
    chk("tmo_set", 64'({dma_timeout, mem_if.dma_en}), 64'b10);
    @(negedge clk);
    chk("tmo_sticky", 64'(dma_timeout), 64'd1);
    @(posedge clk);
    #1 dev_ack = 1'b1; dev_out = 16'h7777; dma_start_address = 16'h0700;
    push_acc(15'h0380, 2'b11, 16'h7777);
    dma_rqst = 1'b1;
    @(negedge clk);
    chk("tmo_before_accept", 64'(dma_timeout), 64'd1);
    @(negedge clk);
    chk("tmo_cleared", 64'(dma_timeout), 64'd0);
    wait_ack("tmo_retry_ack", n);
    @(negedge clk);
    chk("tmo_retry_end", 64'(dma_end_flag), 64'd1);
    drop_rqst("tmo_retry_clr");

    // Address wrap at 0xFFFE, then async reset during the second access.
    @(posedge clk);
    #1 dev_out = 16'h1111; dma_start_address = 16'hFFFE; dma_num_words = 16'd2;
    push_acc(15'h7FFF, 2'b11, 16'h1111);
    dma_rqst = 1'b1;
    wait_ack("wrap_ack0", n);
    @(posedge clk);
    #1 mem_if.dma_ready = 1'b0; dev_out = 16'h2222;
    wait_en("wrap_en1");
    chk("wrap_addr", 64'(mem_if.dma_addr), 64'h0000);
    chk("wrap_we", 64'(mem_if.dma_we), 64'b11);
    chk("wrap_din", 64'(mem_if.dma_din), 64'h2222);
    #2 reset = 1'b1;
    #1 chk("reset_async", outs(), 64'd0);
    @(posedge clk);
    #1 dma_rqst = 1'b0; mem_if.dma_ready = 1'b1;
    @(negedge clk);
    chk("reset_hold", outs(), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("ack_total", 64'(ack_seen), 64'd8);
    chk("acc_left", 64'(exp_acc.size()), 64'd0);
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
